// File: rtl/rsp_frame_tx.sv
// Response frame builder: wraps a read burst from the FIFO as 55 / 1x / addr / data.. / 04 / 0d.
// Latency: first byte strobed the cycle after start; best case one byte every 2 cycles.
// Backpressure: waits on tx_busy before each byte and on fifo_empty before each data byte.
module rsp_frame_tx #(
  parameter int unsigned DATA_NUM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] addr,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       tx_busy,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Framing bytes shared with the command parser.
  localparam logic [7:0] SOF_BYTE = 8'h55;
  localparam logic [7:0] EOT_BYTE = 8'h04;
  localparam logic [7:0] CR_BYTE  = 8'h0d;
  localparam logic [6:0] RD_IND   = 7'b0001000;

  // Byte index map within one frame (9-bit arithmetic, frame is at most 260 bytes).
  localparam logic [8:0] IDX_SOF   = 9'd0;
  localparam logic [8:0] IDX_IND   = 9'd1;
  localparam logic [8:0] IDX_ADDR  = 9'd2;
  localparam logic [8:0] IDX_DATA0 = 9'd3;
  localparam logic [8:0] IDX_DLAST = 9'(DATA_NUM + 2);
  localparam logic [8:0] IDX_EOT   = 9'(DATA_NUM + 3);
  localparam logic [8:0] IDX_END   = 9'(DATA_NUM + 4);

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       blk_q, blk_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dout_q, dout_d;
  logic       vld_q, vld_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] nxt_idx;
  logic       is_data;
  logic [7:0] byte_sel;
  logic       can_issue;
  logic       try_issue;

  // Index of the byte the next SEND cycle would carry: strobes are registered,
  // so the decision is taken one edge ahead of the SEND cycle that shows it.
  always_comb begin
    nxt_idx = cnt_q;
    case (state_q)
      IDLE:    nxt_idx = IDX_SOF;
      HOLD:    nxt_idx = cnt_q + 9'd1;
      default: nxt_idx = cnt_q;
    endcase
  end

  // Content of byte nxt_idx and whether it can go out at the coming edge.
  always_comb begin
    is_data  = (nxt_idx >= IDX_DATA0) && (nxt_idx <= IDX_DLAST);
    byte_sel = CR_BYTE;
    if (nxt_idx == IDX_SOF) begin
      byte_sel = SOF_BYTE;
    end else if (nxt_idx == IDX_IND) begin
      byte_sel = {RD_IND, blk_q};
    end else if (nxt_idx == IDX_ADDR) begin
      byte_sel = adr_q;
    end else if (is_data) begin
      byte_sel = fifo_rdata;
    end else if (nxt_idx == IDX_EOT) begin
      byte_sel = EOT_BYTE;
    end
    // Header/tail bytes are always ready; data bytes need a non-empty FIFO.
    can_issue = !tx_busy && (!is_data || !fifo_empty);
  end

  // Frame sequencer: next state, counter and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    adr_d     = adr_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    rd_d      = 1'b0;
    done_d    = 1'b0;
    try_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d     = addr[8];
          adr_d     = addr[7:0];
          cnt_d     = 9'd0;
          state_d   = SEND;
          try_issue = 1'b1;
        end
      end
      SEND: begin
        // A strobe shown this cycle moves on; otherwise keep trying (no timeout).
        if (vld_q) begin
          state_d = HOLD;
        end else begin
          try_issue = 1'b1;
        end
      end
      HOLD: begin
        // One dead cycle so a UART that raises tx_busy late is still respected.
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == IDX_END) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d   = SEND;
          try_issue = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pop and strobe together so the FIFO head advances before the next SEND.
    if (try_issue && can_issue) begin
      vld_d  = 1'b1;
      dout_d = byte_sel;
      rd_d   = is_data;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 9'd0;
      blk_q   <= 1'b0;
      adr_q   <= 8'h00;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign fifo_rd  = rd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rsp_frame_tx.sv
// Bench for rsp_frame_tx: show-ahead FIFO model, UART busy model, directed frames.
module tb_rsp_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] addr = 9'd0;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd;
  logic       tx_busy;
  logic [7:0] dout;
  logic       dout_vld;
  logic       busy;
  logic       done;

  rsp_frame_tx #(.DATA_NUM(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx_busy    (tx_busy),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: pushes queued by the stimulus land on the next edge.
  logic [7:0] fq[$];
  logic [7:0] pend[$];
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    fifo_empty <= (fq.size() == 0);
    fifo_rdata <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // UART model: busy for busy_len cycles starting the cycle after a strobe.
  int busy_len = 0;
  int bcnt = 0;
  always @(posedge clk) begin
    if (dout_vld && busy_len > 0) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Output monitor on the falling edge.
  int cyc = 0;
  logic [7:0] rx[$];
  int rx_cyc[$];
  int n_pop = 0, n_done = 0, done_cyc = 0;
  int viol_pop = 0, viol_tx = 0;
  always @(negedge clk) begin
    cyc++;
    if (dout_vld) begin
      rx.push_back(dout);
      rx_cyc.push_back(cyc);
      if (tx_busy) viol_tx++;
    end
    if (fifo_rd) begin
      n_pop++;
      if (fifo_empty) viol_pop++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx = {};
    rx_cyc = {};
    n_pop = 0;
    n_done = 0;
  endtask

  task automatic push_all(input logic [7:0] b[$]);
    foreach (b[i]) pend.push_back(b[i]);
    step();
    step();
  endtask

  // Returns in the cycle after start was sampled.
  task automatic pulse_start(input logic [8:0] a);
    addr = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [7:0] e[$]);
    for (int i = 0; i < e.size(); i++) begin
      if (base + i < rx.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(rx[base + i]), 32'(e[i]));
      else
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'hffff_ffff, 32'(e[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_dout"},     32'(dout),     32'h00);
    chk({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
    chk({tag, "_fifo_rd"},  32'(fifo_rd),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] din[$];
  logic [7:0] exp_q[$];

  initial begin
    int k;
    int g;

    // Reset state.
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Full frame with a slow UART.
    busy_len = 4;
    din = {8'hcd, 8'h35, 8'h78, 8'hc5, 8'h2d, 8'h18, 8'hf4, 8'hb7};
    push_all(din);
    clear_mon();
    pulse_start(9'h0cd);
    chk("full_busy_after_start", 32'(busy), 32'd1);
    wait_done("full", 400);
    chk("full_busy_in_done", 32'(busy), 32'd0);
    exp_q = {8'h55, 8'h10, 8'hcd, 8'hcd, 8'h35, 8'h78, 8'hc5, 8'h2d, 8'h18, 8'hf4, 8'hb7, 8'h04, 8'h0d};
    chk("full_len", 32'(rx.size()), 32'd13);
    check_seq("full", 0, exp_q);
    chk("full_pops", 32'(n_pop), 32'd8);
    step();
    chk("full_done_count", 32'(n_done), 32'd1);
    chk("full_busy_after", 32'(busy), 32'd0);

    // Block bit and best-case timing.
    busy_len = 0;
    din = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_all(din);
    clear_mon();
    pulse_start(9'h1a0);
    chk("blk_first_vld", 32'(dout_vld), 32'd1);
    chk("blk_first_byte", 32'(dout), 32'h55);
    wait_done("blk", 200);
    exp_q = {8'h55, 8'h11, 8'ha0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h04, 8'h0d};
    check_seq("blk", 0, exp_q);
    chk("blk_frame_cycles", 32'(done_cyc - ((rx_cyc.size() > 0) ? rx_cyc[0] : -1000)), 32'd26);

    // FIFO stall: three words, the rest 50 cycles later.
    din = {8'ha1, 8'ha2, 8'ha3};
    push_all(din);
    clear_mon();
    pulse_start(9'h042);
    repeat (50) step();
    chk("stall_bytes", 32'(rx.size()), 32'd6);
    chk("stall_pops", 32'(n_pop), 32'd3);
    chk("stall_busy", 32'(busy), 32'd1);
    din = {8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8};
    foreach (din[i]) pend.push_back(din[i]);
    wait_done("stall", 200);
    exp_q = {8'h55, 8'h10, 8'h42, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8, 8'h04, 8'h0d};
    check_seq("stall", 0, exp_q);
    chk("stall_pops_total", 32'(n_pop), 32'd8);

    // Second start mid-frame is ignored.
    din = {8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7};
    push_all(din);
    clear_mon();
    pulse_start(9'h011);
    repeat (6) step();
    pulse_start(9'h1ff);
    wait_done("ignore", 200);
    exp_q = {8'h55, 8'h10, 8'h11, 8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7, 8'h04, 8'h0d};
    check_seq("ignore", 0, exp_q);
    repeat (40) step();
    chk("ignore_len", 32'(rx.size()), 32'd13);
    chk("ignore_done_count", 32'(n_done), 32'd1);
    chk("ignore_busy", 32'(busy), 32'd0);

    // Back-to-back: start in the done cycle.
    din = {8'hd0, 8'hd1, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7,
           8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'he6, 8'he7};
    push_all(din);
    clear_mon();
    pulse_start(9'h100);
    wait_done("b2b_first", 200);
    pulse_start(9'h0ff);
    chk("b2b_next_vld", 32'(dout_vld), 32'd1);
    chk("b2b_next_byte", 32'(dout), 32'h55);
    wait_done("b2b_second", 200);
    exp_q = {8'h55, 8'h11, 8'h00, 8'hd0, 8'hd1, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7, 8'h04, 8'h0d};
    check_seq("b2b_a", 0, exp_q);
    exp_q = {8'h55, 8'h10, 8'hff, 8'he0, 8'he1, 8'he2, 8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'h04, 8'h0d};
    check_seq("b2b_b", 13, exp_q);

    // Reset after the fifth byte, then a clean frame from what is left.
    din = {8'hf0, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7};
    push_all(din);
    clear_mon();
    pulse_start(9'h033);
    k = 0;
    g = 0;
    while (1) begin
      if (dout_vld) k++;
      if (k == 5 || g > 100) break;
      step();
      g++;
    end
    chk("rst_reached_byte5", 32'(k), 32'd5);
    rst = 1'b1;
    step();
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (20) step();
    chk("rst_no_done", 32'(n_done), 32'd0);
    chk("rst_pops", 32'(n_pop), 32'd2);
    chk("rst_bytes", 32'(rx.size()), 32'd5);
    din = {8'hf8, 8'hf9};
    push_all(din);
    clear_mon();
    pulse_start(9'h044);
    wait_done("rst_after", 200);
    exp_q = {8'h55, 8'h10, 8'h44, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8, 8'hf9, 8'h04, 8'h0d};
    check_seq("rst_after", 0, exp_q);

    // Protocol rules over the whole run.
    chk("pop_while_empty", 32'(viol_pop), 32'd0);
    chk("strobe_while_tx_busy", 32'(viol_tx), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
